// File: rtl/pos_ctrl_if.sv
// -----------------------------------------------------------------------------
// pos_ctrl_if
// Bundles the movement/load request side and the position/status side of the
// sprite position controller.
//
// Parameters:
//   X_W, Y_W   coordinate widths (must match the attached pos_ctrl)
//
// Signals:
//   move     [3:0]   movement code, bit 3 = jump request
//   load             synchronous load of x_init/y_init
//   x_init   [X_W]   load value for x
//   y_init   [Y_W]   load value for y
//   posx     [X_W]   current x
//   posy     [Y_W]   current y
//   tick             one-cycle pulse per movement tick
//   jumping          high while a jump arc is in progress
//
// Modports:
//   master   drives move/load/x_init/y_init, observes the status outputs
//   slave    the controller itself
// -----------------------------------------------------------------------------
interface pos_ctrl_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic [3:0]     move;
    logic           load;
    logic [X_W-1:0] x_init;
    logic [Y_W-1:0] y_init;
    logic [X_W-1:0] posx;
    logic [Y_W-1:0] posy;
    logic           tick;
    logic           jumping;

    modport master (
        output move, load, x_init, y_init,
        input  posx, posy, tick, jumping
    );

    modport slave (
        input  move, load, x_init, y_init,
        output posx, posy, tick, jumping
    );
endinterface

// File: rtl/pos_ctrl.sv
// -----------------------------------------------------------------------------
// pos_ctrl
// Sprite position controller. Decodes the keyboard movement code once per
// internal tick and updates a registered (x, y) screen coordinate, either
// wrapping around or clamping at the screen bounds. An optional jump arc
// raises y for JUMP_H ticks and lowers it again for JUMP_H ticks.
//
// Optional feature macro: POS_CTRL_JUMP_EN
//   defined     -> jump FSM (IDLE/RISE/FALL) and jumping output compiled in
//   not defined -> move[3] ignored, up/down always honoured, jumping = 0
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   pos_ctrl_if.slave: move, load, x_init, y_init in;
//         posx, posy, tick, jumping out (all registered)
// -----------------------------------------------------------------------------
module pos_ctrl #(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_RST       = 0,
    parameter int Y_RST       = 0,
    parameter int TICK_CYCLES = 262144,
    parameter int STEP        = 1,
    parameter int WRAP        = 1,
    parameter int JUMP_H      = 32
) (
    input  logic      clk,
    input  logic      rst,
    pos_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

    // Movement arithmetic is done one bit wider than the coordinate so that
    // x+STEP and x+X_MAX+1-STEP never overflow before the bound test.
    localparam logic [X_W:0]   X_TOP  = (X_W+1)'(X_MAX);
    localparam logic [X_W:0]   X_SPAN = (X_W+1)'(X_MAX + 1);
    localparam logic [X_W:0]   X_STEP = (X_W+1)'(STEP);
    localparam logic [Y_W:0]   Y_TOP  = (Y_W+1)'(Y_MAX);
    localparam logic [Y_W:0]   Y_SPAN = (Y_W+1)'(Y_MAX + 1);
    localparam logic [Y_W:0]   Y_STEP = (Y_W+1)'(STEP);
    localparam logic [X_W-1:0] X_LIM  = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM  = Y_W'(Y_MAX);

    localparam logic [2:0] MV_UP    = 3'b001;
    localparam logic [2:0] MV_LEFT  = 3'b010;
    localparam logic [2:0] MV_RIGHT = 3'b011;
    localparam logic [2:0] MV_DOWN  = 3'b100;

    logic [CNT_W-1:0] cnt, cnt_next;
    logic             tick_q;
    logic [X_W-1:0]   posx_q, x_next;
    logic [Y_W-1:0]   posy_q, y_next;

    logic [X_W:0]     x_ext, x_sum, x_left, x_right;
    logic [Y_W:0]     y_ext, y_sum, y_up, y_down, y_rise, y_fall;

    logic             in_jump, in_rise, in_fall;

    // -------------------------------------------------------------------------
    // Tick counter. tick is registered alongside the counter so that it is
    // high exactly while cnt == TICK_CYCLES-1.
    // -------------------------------------------------------------------------
    assign cnt_next = (bus.load || cnt == TICK_LAST) ? '0 : cnt + CNT_W'(1);

    // -------------------------------------------------------------------------
    // Candidate positions for every direction, wrap and clamp variants.
    // -------------------------------------------------------------------------
    always_comb begin
        x_ext = {1'b0, posx_q};
        x_sum = x_ext + X_STEP;
        y_ext = {1'b0, posy_q};
        y_sum = y_ext + Y_STEP;

        if (x_ext >= X_STEP)  x_left = x_ext - X_STEP;
        else if (WRAP != 0)   x_left = x_ext + X_SPAN - X_STEP;
        else                  x_left = '0;

        if (x_sum <= X_TOP)   x_right = x_sum;
        else if (WRAP != 0)   x_right = x_sum - X_SPAN;
        else                  x_right = X_TOP;

        if (y_ext >= Y_STEP)  y_up = y_ext - Y_STEP;
        else if (WRAP != 0)   y_up = y_ext + Y_SPAN - Y_STEP;
        else                  y_up = '0;

        if (y_sum <= Y_TOP)   y_down = y_sum;
        else if (WRAP != 0)   y_down = y_sum - Y_SPAN;
        else                  y_down = Y_TOP;

        // The jump arc always saturates, whatever the edge mode.
        y_rise = (y_ext >= Y_STEP) ? y_ext - Y_STEP : '0;
        y_fall = (y_sum <= Y_TOP)  ? y_sum          : Y_TOP;
    end

`ifdef POS_CTRL_JUMP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } jump_state_t;

    localparam int JC_W = ($clog2(JUMP_H) > 6) ? $clog2(JUMP_H) : 6;
    localparam logic [JC_W-1:0] JC_LAST = JC_W'(JUMP_H - 1);

    jump_state_t     state, state_next;
    logic [JC_W-1:0] jcnt, jcnt_next;

    // Jump FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            jcnt  <= '0;
        end else begin
            state <= state_next;
            jcnt  <= jcnt_next;
        end
    end

    // Jump FSM: next state. Only advances on ticks; load forces IDLE.
    always_comb begin
        state_next = state;
        jcnt_next  = jcnt;
        if (bus.load) begin
            state_next = IDLE;
            jcnt_next  = '0;
        end else if (tick_q) begin
            case (state)
                IDLE: begin
                    if (bus.move[3]) begin
                        state_next = RISE;
                        jcnt_next  = '0;
                    end
                end
                RISE: begin
                    if (jcnt == JC_LAST) begin
                        state_next = FALL;
                        jcnt_next  = '0;
                    end else begin
                        jcnt_next = jcnt + JC_W'(1);
                    end
                end
                FALL: begin
                    if (jcnt == JC_LAST) begin
                        state_next = IDLE;
                        jcnt_next  = '0;
                    end else begin
                        jcnt_next = jcnt + JC_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    jcnt_next  = '0;
                end
            endcase
        end
    end

    // Jump FSM: outputs, decoded from the state register only.
    always_comb begin
        in_rise = (state == RISE);
        in_fall = (state == FALL);
        in_jump = (state != IDLE);
    end
`else
    assign in_rise = 1'b0;
    assign in_fall = 1'b0;
    assign in_jump = 1'b0;

    // The jump request bit and arc height have no effect in this build.
    logic unused_jump;
    assign unused_jump = bus.move[3] ^ (JUMP_H > 0);
`endif

    // -------------------------------------------------------------------------
    // Next position. Load wins over a coincident tick; during a jump the arc
    // owns y while left/right still move x.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the ifs/case can leave it unassigned (a latch).
        x_next = posx_q;
        y_next = posy_q;
        if (bus.load) begin
            x_next = (bus.x_init > X_LIM) ? X_LIM : bus.x_init;
            y_next = (bus.y_init > Y_LIM) ? Y_LIM : bus.y_init;
        end else if (tick_q) begin
            case (bus.move[2:0])
                MV_LEFT:  x_next = x_left[X_W-1:0];
                MV_RIGHT: x_next = x_right[X_W-1:0];
                MV_UP:    if (!in_jump) y_next = y_up[Y_W-1:0];
                MV_DOWN:  if (!in_jump) y_next = y_down[Y_W-1:0];
                default:  ;  // stop and reserved codes 101/110/111
            endcase
            if (in_rise)      y_next = y_rise[Y_W-1:0];
            else if (in_fall) y_next = y_fall[Y_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Position and tick registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tick_q <= 1'b0;
            posx_q <= X_W'(X_RST);
            posy_q <= Y_W'(Y_RST);
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            cnt    <= cnt_next;
            tick_q <= (cnt_next == TICK_LAST);
            posx_q <= x_next;
            posy_q <= y_next;
        end
    end

    assign bus.posx    = posx_q;
    assign bus.posy    = posy_q;
    assign bus.tick    = tick_q;
    assign bus.jumping = in_jump;

endmodule

// File: tb/tb_pos_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pos_ctrl
// Directed bench for pos_ctrl. dut_a: wrap mode, STEP=1, reset point (5,7),
// JUMP_H=3. dut_b: clamp mode, STEP=4. Both tick every 4 clocks.
// -----------------------------------------------------------------------------
module tb_pos_ctrl;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pos_ctrl_if #(.X_W(10), .Y_W(9)) bus_a ();
    pos_ctrl_if #(.X_W(10), .Y_W(9)) bus_b ();

    pos_ctrl #(
        .X_W(10), .Y_W(9), .X_MAX(639), .Y_MAX(479), .X_RST(5), .Y_RST(7),
        .TICK_CYCLES(4), .STEP(1), .WRAP(1), .JUMP_H(3)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    pos_ctrl #(
        .X_W(10), .Y_W(9), .X_MAX(639), .Y_MAX(479), .X_RST(0), .Y_RST(0),
        .TICK_CYCLES(4), .STEP(4), .WRAP(0), .JUMP_H(3)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef POS_CTRL_JUMP_EN
    int ys [6] = '{99, 98, 97, 98, 99, 100};
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic load_a(input logic [9:0] xi, input logic [8:0] yi);
        bus_a.load = 1'b1; bus_a.x_init = xi; bus_a.y_init = yi;
        @(negedge clk);
        bus_a.load = 1'b0;
    endtask

    task automatic load_b(input logic [9:0] xi, input logic [8:0] yi);
        bus_b.load = 1'b1; bus_b.x_init = xi; bus_b.y_init = yi;
        @(negedge clk);
        bus_b.load = 1'b0;
    endtask

    // Advance to the negedge inside the next tick cycle (bounded).
    task automatic wait_tick(input bit use_b, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((use_b ? bus_b.tick : bus_a.tick) !== 1'b1) && n < 16);
        check({tag, "_tick"}, 32'(use_b ? bus_b.tick : bus_a.tick), 1);
    endtask

    // Let one movement tick take effect; returns where the new position shows.
    task automatic step(input bit use_b, input string tag);
        wait_tick(use_b, tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        bus_a.move = 4'b0000; bus_a.load = 1'b0; bus_a.x_init = '0; bus_a.y_init = '0;
        bus_b.move = 4'b0000; bus_b.load = 1'b0; bus_b.x_init = '0; bus_b.y_init = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_posx",    32'(bus_a.posx),    5);
        check("rst_posy",    32'(bus_a.posy),    7);
        check("rst_tick",    32'(bus_a.tick),    0);
        check("rst_jumping", 32'(bus_a.jumping), 0);
        check("rst_b_posx",  32'(bus_b.posx),    0);
        rst = 1'b0;

        // First tick at cycle 3, then every 4 cycles.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("tick_cyc%0d", i), 32'(bus_a.tick), (i % 4 == 3) ? 1 : 0);
        end
        check("stop_posx", 32'(bus_a.posx), 5);

        // Wrap-around at every edge.
        load_a(10'd0, 9'd0);
        check("load_posx", 32'(bus_a.posx), 0);
        check("load_posy", 32'(bus_a.posy), 0);
        bus_a.move = 4'b0010; step(0, "wrap_left");
        check("wrap_left_posx", 32'(bus_a.posx), 639);
        bus_a.move = 4'b0011; step(0, "wrap_right");
        check("wrap_right_posx", 32'(bus_a.posx), 0);
        bus_a.move = 4'b0001; step(0, "wrap_up");
        check("wrap_up_posy", 32'(bus_a.posy), 479);
        bus_a.move = 4'b0100; step(0, "wrap_down");
        check("wrap_down_posy", 32'(bus_a.posy), 0);
        bus_a.move = 4'b0111; step(0, "reserved");
        check("reserved_posx", 32'(bus_a.posx), 0);
        check("reserved_posy", 32'(bus_a.posy), 0);

        load_a(10'd10, 9'd100);
`ifdef POS_CTRL_JUMP_EN
        bus_a.move = 4'b1011; step(0, "jump_accept");
        check("jump_accept_posx",    32'(bus_a.posx),    11);
        check("jump_accept_posy",    32'(bus_a.posy),    100);
        check("jump_accept_jumping", 32'(bus_a.jumping), 1);
        for (int i = 0; i < 6; i++) begin
            step(0, "arc");
            check($sformatf("arc%0d_posy", i),    32'(bus_a.posy),    ys[i]);
            check($sformatf("arc%0d_posx", i),    32'(bus_a.posx),    12 + i);
            check($sformatf("arc%0d_jumping", i), 32'(bus_a.jumping), (i < 5) ? 1 : 0);
        end
        bus_a.move = 4'b1000; step(0, "jump2_accept");
        check("jump2_jumping", 32'(bus_a.jumping), 1);
        check("jump2_posy",    32'(bus_a.posy),    100);
        bus_a.move = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step(0, "rise_down");
            check($sformatf("rise_down%0d_posy", i), 32'(bus_a.posy), 99 - i);
            check($sformatf("rise_down%0d_posx", i), 32'(bus_a.posx), 17);
        end
`else
        bus_a.move = 4'b1011; step(0, "nojump_right");
        check("nojump_posx",    32'(bus_a.posx),    11);
        check("nojump_posy",    32'(bus_a.posy),    100);
        check("nojump_jumping", 32'(bus_a.jumping), 0);
        bus_a.move = 4'b1001; step(0, "nojump_up");
        check("nojump_up_posy", 32'(bus_a.posy), 99);
        bus_a.move = 4'b1100; step(0, "nojump_down");
        check("nojump_down_posy", 32'(bus_a.posy), 100);
        check("nojump_down_jumping", 32'(bus_a.jumping), 0);
`endif

        // Load on a tick cycle (mid-jump in the jump build), with clamping.
        bus_a.move = 4'b0000;
        wait_tick(0, "load_on_tick");
        load_a(10'd700, 9'd20);
        check("ldtick_posx",    32'(bus_a.posx),    639);
        check("ldtick_posy",    32'(bus_a.posy),    20);
        check("ldtick_jumping", 32'(bus_a.jumping), 0);
        check("ldtick_cyc1",    32'(bus_a.tick),    0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("ldtick_cyc%0d", i), 32'(bus_a.tick), (i == 4) ? 1 : 0);
        end
        bus_a.move = 4'b0100;
        @(negedge clk);
        check("after_load_down_posy", 32'(bus_a.posy), 21);

        // Asynchronous reset between clock edges.
`ifdef POS_CTRL_JUMP_EN
        bus_a.move = 4'b1000; step(0, "rst_jump_accept");
        step(0, "rst_jump_rise");
        check("pre_rst_posy",    32'(bus_a.posy),    20);
        check("pre_rst_jumping", 32'(bus_a.jumping), 1);
`else
        bus_a.move = 4'b0011; step(0, "pre_rst_move");
        check("pre_rst_posx", 32'(bus_a.posx), 0);
`endif
        bus_a.move = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("async_rst_posx",    32'(bus_a.posx),    5);
        check("async_rst_posy",    32'(bus_a.posy),    7);
        check("async_rst_jumping", 32'(bus_a.jumping), 0);
        check("async_rst_tick",    32'(bus_a.tick),    0);
        #1 rst = 1'b0;
        step(0, "post_rst");
        check("post_rst_posy",    32'(bus_a.posy),    7);
        check("post_rst_jumping", 32'(bus_a.jumping), 0);

        // Clamp mode, STEP=4.
        load_b(10'd2, 9'd0);
        bus_b.move = 4'b0010; step(1, "clamp_left");
        check("clamp_left_posx", 32'(bus_b.posx), 0);
        step(1, "clamp_left_hold");
        check("clamp_left_hold_posx", 32'(bus_b.posx), 0);
        load_b(10'd637, 9'd477);
        bus_b.move = 4'b0011; step(1, "clamp_right");
        check("clamp_right_posx", 32'(bus_b.posx), 639);
        step(1, "clamp_right_hold");
        check("clamp_right_hold_posx", 32'(bus_b.posx), 639);
        bus_b.move = 4'b0100; step(1, "clamp_down");
        check("clamp_down_posy", 32'(bus_b.posy), 479);
        load_b(10'd100, 9'd2);
        bus_b.move = 4'b0001; step(1, "clamp_up");
        check("clamp_up_posy", 32'(bus_b.posy), 0);
        bus_b.move = 4'b0010; step(1, "step_left");
        check("step_left_posx", 32'(bus_b.posx), 96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
